// File: rtl/elevator_pkg.sv
// elevator_pkg: definitions shared by the elevator controller blocks.
//   NUM_FLOORS_DEFAULT : default number of floors
//   FLOOR_W / floor_t  : floor index width and type at the default size
//   dir_e              : travel direction, same encoding as the motor drive
package elevator_pkg;

  localparam int NUM_FLOORS_DEFAULT = 3;
  localparam int FLOOR_W            = $clog2(NUM_FLOORS_DEFAULT);

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_DOWN = 2'b01,
    DIR_UP   = 2'b10
  } dir_e;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer followed by a debounce counter for one
// raw push button. A new level is accepted only after the synchronized input
// has differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   btn_raw : asynchronous raw button, active-high
//   rise    : one-cycle pulse, registered, the cycle after the accepted
//             level goes 0 -> 1
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // The counter would reach DEBOUNCE_CYCLES: accept the new level.
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/elevator_call_register.sv
// elevator_call_register: synchronizes and debounces the cab and hall
// buttons, latches them as pending calls, clears calls as the controller
// serves floors, and summarizes pending calls relative to the current floor.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   btn_cab/btn_up/btn_down        : raw async buttons, one bit per floor
//                                    (btn_up top bit and btn_down bit 0 unused)
//   cur_floor                      : floor the car is at or last passed
//   serve_valid/serve_floor/dir    : service pulse from the controller
//   pend_cab/pend_up/pend_down     : latched calls
//   req_above/req_below/req_here   : pending call above / below / at cur_floor
//   any_pending                    : any call pending anywhere
// Build option:
//   CALL_CANCEL_EN : a new press of an already pending cab call cancels it.
module elevator_call_register
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = NUM_FLOORS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int FW             = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn_cab,
  input  logic [NUM_FLOORS-1:0] btn_up,
  input  logic [NUM_FLOORS-1:0] btn_down,
  input  logic [FW-1:0]         cur_floor,
  input  logic                  serve_valid,
  input  logic [FW-1:0]         serve_floor,
  input  logic [1:0]            serve_dir,
  output logic [NUM_FLOORS-1:0] pend_cab,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_down,
  output logic                  req_above,
  output logic                  req_below,
  output logic                  req_here,
  output logic                  any_pending
);

  logic [NUM_FLOORS-1:0] rise_cab, rise_up, rise_down;
  logic [NUM_FLOORS-1:0] clr_cab, clr_up, clr_down;
  logic [NUM_FLOORS-1:0] cab_nxt, up_nxt, down_nxt;
  logic [NUM_FLOORS-1:0] call_at;
  logic                  unused_btn;

  // No hall-up button at the top floor and no hall-down at the bottom.
  assign unused_btn = btn_up[NUM_FLOORS-1] ^ btn_down[0];

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cab (
      .clk(clk), .rst(rst), .btn_raw(btn_cab[f]), .rise(rise_cab[f])
    );
    if (f < NUM_FLOORS - 1) begin : g_up
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn_raw(btn_up[f]), .rise(rise_up[f])
      );
    end else begin : g_no_up
      assign rise_up[f] = 1'b0;
    end
    if (f > 0) begin : g_down
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst(rst), .btn_raw(btn_down[f]), .rise(rise_down[f])
      );
    end else begin : g_no_down
      assign rise_down[f] = 1'b0;
    end
  end

  // Hall calls in the leaving direction are answered; at a terminal floor the
  // car can only go one way, so the opposite hall call is answered too.
  always_comb begin
    clr_cab  = '0;
    clr_up   = '0;
    clr_down = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (serve_valid && int'(serve_floor) == f) begin
        clr_cab[f] = 1'b1;
        case (serve_dir)
          DIR_UP: begin
            clr_up[f]   = 1'b1;
            clr_down[f] = (f == NUM_FLOORS - 1);
          end
          DIR_DOWN: begin
            clr_down[f] = 1'b1;
            clr_up[f]   = (f == 0);
          end
          DIR_IDLE: begin
            clr_up[f]   = 1'b1;
            clr_down[f] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Clear has priority over a set or cancel landing on the same bit.
`ifdef CALL_CANCEL_EN
  assign cab_nxt = (pend_cab ^ rise_cab) & ~clr_cab;
`else
  assign cab_nxt = (pend_cab | rise_cab) & ~clr_cab;
`endif
  assign up_nxt   = (pend_up   | rise_up)   & ~clr_up;
  assign down_nxt = (pend_down | rise_down) & ~clr_down;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cab  <= '0;
      pend_up   <= '0;
      pend_down <= '0;
    end else begin
      pend_cab  <= cab_nxt;
      pend_up   <= up_nxt;
      pend_down <= down_nxt;
    end
  end

  assign call_at     = pend_cab | pend_up | pend_down;
  assign any_pending = |call_at;

  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    req_here  = 1'b0;
    if (int'(cur_floor) < NUM_FLOORS) begin
      for (int f = 0; f < NUM_FLOORS; f++) begin
        if (call_at[f]) begin
          if (f > int'(cur_floor))      req_above = 1'b1;
          else if (f < int'(cur_floor)) req_below = 1'b1;
          else                          req_here  = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_elevator_call_register.sv
// tb_elevator_call_register: directed scenarios plus a randomized run, all
// compared against a behavioural model of the call register kept here.
module tb_elevator_call_register;

  localparam int NF = 3;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] btn_cab, btn_up, btn_down;
  logic [1:0]    cur_floor, serve_floor, serve_dir;
  logic          serve_valid;
  logic [NF-1:0] pend_cab, pend_up, pend_down;
  logic          req_above, req_below, req_here, any_pending;
  logic [12:0]   dut_all;

  int n_assert = 0;
  int n_fail   = 0;

  elevator_call_register dut (
    .clk(clk), .rst(rst),
    .btn_cab(btn_cab), .btn_up(btn_up), .btn_down(btn_down),
    .cur_floor(cur_floor),
    .serve_valid(serve_valid), .serve_floor(serve_floor), .serve_dir(serve_dir),
    .pend_cab(pend_cab), .pend_up(pend_up), .pend_down(pend_down),
    .req_above(req_above), .req_below(req_below), .req_here(req_here),
    .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  assign dut_all = {pend_cab, pend_up, pend_down, req_above, req_below, req_here, any_pending};

  // ---------------- reference model ----------------
  // kind 0 = cab, 1 = hall up, 2 = hall down.
  // A button's level is accepted once the raw samples taken 2..DB+1 edges ago
  // all agree on a value different from the accepted one; the call latches at
  // the following edge.
  bit [DB+1:0] hist  [3][NF];
  bit          lvl   [3][NF];
  bit          mrise [3][NF];
  bit          mpend [3][NF];

  function automatic bit raw_of(int k, int f);
    if (k == 0) return btn_cab[f];
    if (k == 1) return btn_up[f];
    return btn_down[f];
  endfunction

  function automatic bit serve_clears(int k, int f);
    if (!serve_valid || int'(serve_floor) != f) return 1'b0;
    if (k == 0) return 1'b1;
    if (k == 1) return serve_dir == 2'b00 || serve_dir == 2'b10 || (serve_dir == 2'b01 && f == 0);
    return serve_dir == 2'b00 || serve_dir == 2'b01 || (serve_dir == 2'b10 && f == NF - 1);
  endfunction

  always @(posedge clk) begin
    bit        setb, np;
    bit [DB-1:0] win;
    for (int k = 0; k < 3; k++) begin
      for (int f = 0; f < NF; f++) begin
        if (rst) begin
          hist[k][f] = '0; lvl[k][f] = 0; mrise[k][f] = 0; mpend[k][f] = 0;
        end else begin
          setb = mrise[k][f] && !(k == 1 && f == NF - 1) && !(k == 2 && f == 0);
          np   = mpend[k][f] | setb;
`ifdef CALL_CANCEL_EN
          if (k == 0 && setb && mpend[k][f]) np = 1'b0;
`endif
          if (serve_clears(k, f)) np = 1'b0;
          mpend[k][f] = np;
          hist[k][f]  = {hist[k][f][DB:0], raw_of(k, f)};
          win         = hist[k][f][DB+1:2];
          mrise[k][f] = 1'b0;
          if (!lvl[k][f] && win == '1) begin
            lvl[k][f] = 1'b1; mrise[k][f] = 1'b1;
          end else if (lvl[k][f] && win == '0) begin
            lvl[k][f] = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [12:0] exp_all();
    logic [NF-1:0] c = '0, u = '0, d = '0;
    logic a = 0, b = 0, h = 0, any = 0, at;
    int cf = int'(cur_floor);
    for (int f = 0; f < NF; f++) begin
      c[f] = mpend[0][f]; u[f] = mpend[1][f]; d[f] = mpend[2][f];
      at   = c[f] | u[f] | d[f];
      any  = any | at;
      if (at && cf < NF) begin
        if (f > cf) a = 1; else if (f < cf) b = 1; else h = 1;
      end
    end
    return {c, u, d, a, b, h, any};
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; step(3);
    n_assert++;
    if (dut_all !== 13'd0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0", dut_all); end
    n_assert++;
    if (dut_all !== exp_all()) begin n_fail++; $display("FAIL reset_model: got %b want %b", dut_all, exp_all()); end
    rst = 1'b0; step(2);
  endtask

  task automatic test_latency();
    cur_floor = 2'd0;
    btn_cab   = 3'b100;
    for (int j = 1; j <= 10; j++) begin
      step(1);
      n_assert++;
      if (pend_cab !== ((j >= 7) ? 3'b100 : 3'b000)) begin
        n_fail++; $display("FAIL latency_cycle%0d: pend_cab=%b want %b", j, pend_cab, (j >= 7) ? 3'b100 : 3'b000);
      end
      if (j == 7) begin
        n_assert++;
        if ({req_above, req_below, req_here, any_pending} !== 4'b1001) begin
          n_fail++; $display("FAIL latency_summary: got %b want 1001", {req_above, req_below, req_here, any_pending});
        end
      end
    end
    btn_cab = 3'b000; step(8);
    n_assert++;
    if (dut_all !== exp_all()) begin n_fail++; $display("FAIL latency_model: got %b want %b", dut_all, exp_all()); end
  endtask

  task automatic test_glitch();
    btn_up = 3'b010; step(3);
    btn_up = 3'b000; step(10);
    n_assert++;
    if (pend_up !== 3'b000) begin n_fail++; $display("FAIL glitch_rejected: pend_up=%b want 000", pend_up); end
    btn_up = 3'b010; step(8);
    n_assert++;
    if (pend_up !== 3'b010) begin n_fail++; $display("FAIL hold_latched: pend_up=%b want 010", pend_up); end
    step(12);
    n_assert++;
    if (dut_all !== exp_all() || pend_up !== 3'b010) begin
      n_fail++; $display("FAIL hold_single_call: got %b want %b", dut_all, exp_all());
    end
    btn_up = 3'b000; step(8);
  endtask

  task automatic test_serve_up();
    btn_cab = 3'b010; btn_down = 3'b010; step(8);
    btn_cab = 3'b000; btn_down = 3'b000; step(8);
    n_assert++;
    if ({pend_cab, pend_up, pend_down} !== 9'b110_010_010) begin
      n_fail++; $display("FAIL serve_setup: got %b want 110010010", {pend_cab, pend_up, pend_down});
    end
    serve_valid = 1'b1; serve_floor = 2'd1; serve_dir = 2'b10; step(1);
    serve_valid = 1'b0;
    n_assert++;
    if ({pend_cab, pend_up, pend_down} !== 9'b100_000_010) begin
      n_fail++; $display("FAIL serve_dir_up: got %b want 100000010", {pend_cab, pend_up, pend_down});
    end
    n_assert++;
    if (dut_all !== exp_all()) begin n_fail++; $display("FAIL serve_model: got %b want %b", dut_all, exp_all()); end
  endtask

  task automatic test_set_clear_collision();
    btn_down = 3'b101; btn_up = 3'b100;
    step(6);
    serve_valid = 1'b1; serve_floor = 2'd2; serve_dir = 2'b00;
    step(1);
    serve_valid = 1'b0;
    n_assert++;
    if (pend_down !== 3'b010) begin n_fail++; $display("FAIL clear_wins: pend_down=%b want 010", pend_down); end
    step(12);
    n_assert++;
    if (pend_up !== 3'b000 || pend_down !== 3'b010) begin
      n_fail++; $display("FAIL ignored_bits: pend_up=%b pend_down=%b want 000 010", pend_up, pend_down);
    end
    btn_down = 3'b000; btn_up = 3'b000; step(8);
    serve_valid = 1'b1; serve_floor = 2'd3; serve_dir = 2'b00; step(1);
    serve_valid = 1'b0;
    n_assert++;
    if (pend_down !== 3'b010 || dut_all !== exp_all()) begin
      n_fail++; $display("FAIL serve_out_of_range: got %b want %b", dut_all, exp_all());
    end
  endtask

  task automatic test_summary_and_reset();
    btn_cab = 3'b101; step(8);
    btn_cab = 3'b000; step(8);
    serve_valid = 1'b1; serve_floor = 2'd1; serve_dir = 2'b00; step(1);
    serve_valid = 1'b0;
    cur_floor = 2'd1; step(1);
    n_assert++;
    if ({req_above, req_below, req_here, any_pending} !== 4'b1101) begin
      n_fail++; $display("FAIL summary_floor1: got %b want 1101", {req_above, req_below, req_here, any_pending});
    end
    cur_floor = 2'd0; step(1);
    n_assert++;
    if ({req_above, req_below, req_here} !== 3'b101) begin
      n_fail++; $display("FAIL summary_floor0: got %b want 101", {req_above, req_below, req_here});
    end
    cur_floor = 2'd3; step(1);
    n_assert++;
    if ({req_above, req_below, req_here, any_pending} !== 4'b0001) begin
      n_fail++; $display("FAIL summary_out_of_range: got %b want 0001", {req_above, req_below, req_here, any_pending});
    end
    rst = 1'b1; step(1);
    rst = 1'b0; cur_floor = 2'd0;
    n_assert++;
    if (dut_all !== 13'd0) begin n_fail++; $display("FAIL reset_mid_op: got %b want 0", dut_all); end
    step(2);
  endtask

  task automatic test_cancel();
    btn_cab = 3'b001; step(8);
    btn_cab = 3'b000; step(8);
    n_assert++;
    if (pend_cab !== 3'b001) begin n_fail++; $display("FAIL cancel_setup: pend_cab=%b want 001", pend_cab); end
    btn_cab = 3'b001; step(8);
    btn_cab = 3'b000; step(8);
    n_assert++;
`ifdef CALL_CANCEL_EN
    if (pend_cab !== 3'b000) begin n_fail++; $display("FAIL cancel_repress: pend_cab=%b want 000", pend_cab); end
`else
    if (pend_cab !== 3'b001) begin n_fail++; $display("FAIL cancel_repress: pend_cab=%b want 001", pend_cab); end
`endif
  endtask

  task automatic test_reset_held_button();
    btn_cab = 3'b010; step(8);
    rst = 1'b1; step(2);
    n_assert++;
    if (dut_all !== 13'd0) begin n_fail++; $display("FAIL held_reset_clear: got %b want 0", dut_all); end
    rst = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step(1);
      n_assert++;
      if (pend_cab[1] !== (j >= 7)) begin
        n_fail++; $display("FAIL held_relatch_cycle%0d: pend_cab[1]=%b want %b", j, pend_cab[1], (j >= 7));
      end
    end
    btn_cab = 3'b000; step(8);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1);
      n_assert++;
      if (dut_all !== exp_all()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %b want %b", i, dut_all, exp_all());
      end
      for (int f = 0; f < NF; f++) begin
        if ($urandom_range(0, 9) == 0) btn_cab[f]  = ~btn_cab[f];
        if ($urandom_range(0, 9) == 0) btn_up[f]   = ~btn_up[f];
        if ($urandom_range(0, 9) == 0) btn_down[f] = ~btn_down[f];
      end
      serve_valid = ($urandom_range(0, 11) == 0);
      serve_floor = 2'($urandom_range(0, 3));
      serve_dir   = 2'($urandom_range(0, 2));
      cur_floor   = 2'($urandom_range(0, 3));
      rst         = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0; serve_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_cab = '0; btn_up = '0; btn_down = '0;
    cur_floor = '0; serve_valid = 1'b0; serve_floor = '0; serve_dir = '0;
    test_reset();
    test_latency();
    test_glitch();
    test_serve_up();
    test_set_clear_collision();
    test_summary_and_reset();
    test_cancel();
    test_reset_held_button();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_call_register.md
Name: elevator_call_register

Overview:
- Upstream stage of the elevator controller.
- Takes raw asynchronous cab and hall buttons, synchronizes and debounces them, and latches them as pending calls.
- Clears calls when the controller reports service at a floor.
- Presents pending-call vectors plus above/below/here summaries relative to the current floor, so the controller's state machine reads clean, glitch-free request flags.

Parameters:
- NUM_FLOORS, 3, number of floors; floor index 0..NUM_FLOORS-1.
- DEBOUNCE_CYCLES, 4, consecutive clk cycles a synchronized button must hold a new level before it is accepted (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- btn_cab  in  NUM_FLOORS  raw cab (car) buttons, async, active-high
- btn_up  in  NUM_FLOORS  raw hall-up buttons; bit NUM_FLOORS-1 ignored
- btn_down  in  NUM_FLOORS  raw hall-down buttons; bit 0 ignored
- cur_floor  in  $clog2(NUM_FLOORS)  floor the car is at or last passed, from controller
- serve_valid  in  1  one-cycle pulse: car stopped with door open at serve_floor
- serve_floor  in  $clog2(NUM_FLOORS)  floor being served
- serve_dir  in  2  10=leaving up, 01=leaving down, 00=idle/no direction
- pend_cab  out  NUM_FLOORS  latched cab calls (also drives cab lamps)
- pend_up  out  NUM_FLOORS  latched hall-up calls
- pend_down  out  NUM_FLOORS  latched hall-down calls
- req_above  out  1  any pending call at a floor > cur_floor
- req_below  out  1  any pending call at a floor < cur_floor
- req_here  out  1  any pending call at cur_floor
- any_pending  out  1  OR of all pending bits

Behaviour:

Reset:
- All pend_* = 0, all summaries = 0.
- Sync flops, debounced levels and counters = 0.

Input path (per button):
- 2-FF synchronizer, then debounce counter.
- Counter increments while the synchronized value differs from the debounced level and resets to 0 when they match.
- When the counter would reach DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.

Latching:
- Rising edge of a debounced level sets the pending bit one cycle later.
- Latency: button high and sampled at edge k -> pending at edge k+2+DEBOUNCE_CYCLES (k+6 at default).
- Glitches shorter than DEBOUNCE_CYCLES never latch.
- Holding a button generates one call only; re-arming requires a debounced release.
- Ignored bits (btn_up[top], btn_down[0]) never set.

Clear on serve_valid at floor F:
- pend_cab[F] always clears.
- serve_dir=10: clear pend_up[F]; at top floor also clear pend_down[F].
- serve_dir=01: clear pend_down[F]; at floor 0 also clear pend_up[F].
- serve_dir=00: clear pend_up[F] and pend_down[F].

Simultaneous events:
- Set and clear of the same bit in one cycle: clear wins (the call is being served).
- Sets on other bits are unaffected.
- serve_floor >= NUM_FLOORS: no effect.

Summaries:
- Combinational from pend_* registers and cur_floor; no extra latency.
- Out-of-range cur_floor: all three summaries = 0.

Reset mid-operation:
- Clears everything in one cycle.
- A button held through reset re-latches after the full debounce latency following rst deassertion.

Optional Feature:
- Macro: CALL_CANCEL_EN.
- Defined: a new debounced press of a cab button whose pend_cab bit is already set clears that bit (passenger cancel). Hall calls are unaffected. If a cancel and serve_valid hit the same bit in one cycle, the result is cleared.
- Undefined: re-press of a pending cab call is ignored and the bit stays set.

Decomposition:
- Shared package elevator_pkg holds:
  - NUM_FLOORS default
  - floor index width and typedef floor_t
  - direction encoding DIR_IDLE=2'b00, DIR_DOWN=2'b01, DIR_UP=2'b10, shared with the controller's motor-drive encoding
- One sub-module, button_debounce: synchronizer + counter + debounced level + rise pulse, instantiated per button.

Test Plan:
1. rst, cur_floor=0, pulse btn_cab[2] high for 10 cycles -> pend_cab=3'b100 exactly 6 cycles after first sample; req_above=1, req_below=0, any_pending=1.
2. btn_up[1] glitch of 3 cycles -> pend_up stays 0. Then held 8 cycles -> pend_up[1]=1 once; holding longer adds nothing.
3. pend_up[1]=pend_down[1]=pend_cab[1]=1; serve_valid, serve_floor=1, serve_dir=10 -> pend_cab[1]=0, pend_up[1]=0, pend_down[1]=1.
4. Debounced rise of btn_down[2] lands in the same cycle as serve_valid floor 2, dir 00 -> pend_down[2]=0. btn_up[2] and btn_down[0] held -> never latch.
5. Calls pending at floors 0 and 2, cur_floor=1 -> req_above=1, req_below=1, req_here=0. Assert rst for 1 cycle -> all outputs 0 next edge.
6. CALL_CANCEL_EN defined: pend_cab[0]=1, release and press btn_cab[0] again -> pend_cab[0]=0. Undefined: same stimulus -> pend_cab[0] stays 1.
